pe_tile_param: RTL
==================

# pe_tile_param

Parametrised PE tile: the next-generation replacement for the fixed-position, 1-bit, 4-track tile variants. It carries a four-sided switch box with per-output pipeline registers, two connect boxes, and a 2-input LUT logic block with an optional output flop. A per-tile configuration register bank has write-enable and registered readback. Tiles abut in the array fabric. Edge and corner behaviour is selected by `SIDE_MASK` instead of separate modules.

## Interface
- `NUM_TRACKS`, default 4: tracks per side, 1..8.
- `TRACK_WIDTH`, default 1: bits per track, 1..32.
- `SIDE_MASK`, default 4'b1111: bit s=1 enables outputs on side s; disabled sides drive 0.
- `clk`  in  1  single clock; all state updates on its rising edge.
- `reset`  in  1  synchronous, active-high reset, sampled on the rising edge of `clk`.
- `tile_id`  in  16  tile identity, static.
- `config_addr`  in  32  [15:0] tile id, [31:16] module id.
- `config_data`  in  32  write data.
- `config_en`  in  1  write strobe.
- `config_rd`  in  1  readback strobe.
- `config_rdata`  out  32  readback data, registered.
- `config_rvalid`  out  1  high one cycle after an addressed `config_rd`.
- `in_wire`  in  4*NUM_TRACKS*TRACK_WIDTH  track (s,t) at bits [(s*NUM_TRACKS+t)*TRACK_WIDTH +: TRACK_WIDTH].
- `out_wire`  out  4*NUM_TRACKS*TRACK_WIDTH  same packing as `in_wire`.
- `pe_out`  out  TRACK_WIDTH  logic block output, for debug and observation.

## Operation
- Address hit: `config_addr[15:0] == tile_id`. Module ids:
  - 0x0000: CLB.
  - 0x0001: CB0.
  - 0x0002: CB1.
  - 0x0100 + 16*s + t: SB output (s,t), with s<4 and t<NUM_TRACKS.
  - Any other id: no write; readback returns 0.
- CLB register, reset 0:
  - [3:0] LUT truth table. Out bit i = LUT[{op1[i],op0[i]}], computed bitwise over TRACK_WIDTH.
  - [4] reg_mode. 0 = `pe_out` is combinational; 1 = `pe_out` comes from a flop.
- CB0/CB1 registers, reset 0:
  - [3:0] select. Values 0..NUM_TRACKS-1 pick `in_wire` side 0, track sel.
  - Values NUM_TRACKS..2*NUM_TRACKS-1 pick side 1, track sel-NUM_TRACKS.
  - Values ≥2*NUM_TRACKS give 0.
  - CB0 drives op0; CB1 drives op1.
- SB register (s,t):
  - [2:0] sel, reset 3'b111. Values 0..3 pick `in_wire` (sel,t); U-turn when sel==s is legal. 4 picks `pe_out`. 5..7 give constant 0.
  - [3] reg_mode, reset 0. When 1, output (s,t) comes from a flop capturing the mux value.
- Write: on a clock edge with `config_en` and an address hit, the register loads `config_data` masked to its field width. Unused bits read back as 0.
- Readback: on a clock edge with `config_rd` and a tile hit:
  - `config_rdata` loads the pre-edge value of the addressed register; `config_rvalid` is 1.
  - Otherwise `config_rvalid` is 0 and `config_rdata` holds its value.
- Sides with `SIDE_MASK[s]`=0: outputs are hard 0. Their SB registers still exist and still read back.

## Timing
- Reset values: all `out_wire` 0 (sel=7), `pe_out` 0, `config_rdata` 0, `config_rvalid` 0, all data and pipeline flops 0.
- Reset has priority over a simultaneous write or readback. Mid-operation reset clears the configuration and all flops on that edge.
- Config write takes effect on the edge it is sampled. The new routing is visible combinationally immediately after that edge.
- Readback latency: 1 cycle.
- Write and read to the same register on the same edge: `config_rdata` returns the old value.
- Both strobes may be high together; both are serviced.
- Route path latency:
  - Unregistered SB output: 0 cycles, combinational.
  - Registered SB output: 1 cycle.
  - CLB reg_mode=1 adds 1 cycle.
  - Registered CLB output routed through a registered SB output: 2 cycles.
- Pipeline flops update every cycle regardless of config activity.
- No combinational loops inside the tile: CB sources are `in_wire` only. Loops through the array are the user's responsibility.

## Test plan
- Reset: assert `reset` 2 cycles with `config_en`=1. After release, all `out_wire`=0, `config_rvalid`=0, and reading SB(2,1) returns 0x7.
- Pass-through: write SB(2,1) data 0x0, drive in_wire(0,1)=1 → out_wire(2,1)=1 in the same cycle. Write 0x8 → out_wire(2,1) follows in_wire(0,1) one cycle late.
- LUT: CB0=0, CB1=NUM_TRACKS, CLB=0x8 (AND), SB(1,0)=0x4. Drive in(0,0)=1, in(1,0)=1 → out(1,0)=1; in(1,0)=0 → 0. CLB=0x18 → 1-cycle delay.
- Address filter: write with `tile_id` mismatch, then with unknown module id 0x0005. Both leave the registers unchanged; readback of 0x0005 returns 0 with `config_rvalid`=1.
- SIDE_MASK=4'b0111: SB(3,0)=0x0 with in(0,0)=1 → out(3,0) stays 0; readback of SB(3,0)=0x0.
- Simultaneous: write CB0=0x3 and read CB0 on the same edge → `config_rdata`=old 0x0. Next read → 0x3.

Source files
------------

// File: rtl/pe_tile_param.sv
// pe_tile_param
// Parametrised PE tile: four-sided switch box with optional per-output
// pipeline flops, two connect boxes feeding a 2-input bitwise LUT with an
// optional output flop, and a per-tile configuration register bank with
// write and registered readback.
//
// Ports
//   i_clk, i_reset     : clock, synchronous active-high reset
//   i_tile_id          : static identity of this tile in the array
//   i_config_addr      : [15:0] tile id, [31:16] module id
//   i_config_data      : write data
//   i_config_en        : write strobe
//   i_config_rd        : readback strobe
//   o_config_rdata     : registered readback data
//   o_config_rvalid    : high one cycle after an addressed readback
//   i_in_wire          : tracks, (s,t) at [(s*NUM_TRACKS+t)*TRACK_WIDTH +: TRACK_WIDTH]
//   o_out_wire         : same packing as i_in_wire
//   o_pe_out           : logic block output
//
// Config handshake: a strobe is accepted on any rising edge where it is high
// and i_config_addr[15:0] matches i_tile_id; there is no back-pressure.
// o_config_rvalid qualifies o_config_rdata for exactly one cycle.
module pe_tile_param #(
    parameter int         NUM_TRACKS  = 4,
    parameter int         TRACK_WIDTH = 1,
    parameter logic [3:0] SIDE_MASK   = 4'b1111
) (
    input  logic                                  i_clk,
    input  logic                                  i_reset,
    input  logic [15:0]                           i_tile_id,
    input  logic [31:0]                           i_config_addr,
    input  logic [31:0]                           i_config_data,
    input  logic                                  i_config_en,
    input  logic                                  i_config_rd,
    output logic [31:0]                           o_config_rdata,
    output logic                                  o_config_rvalid,
    input  logic [4*NUM_TRACKS*TRACK_WIDTH-1:0]   i_in_wire,
    output logic [4*NUM_TRACKS*TRACK_WIDTH-1:0]   o_out_wire,
    output logic [TRACK_WIDTH-1:0]                o_pe_out
);

    localparam int NT = NUM_TRACKS;
    localparam int TW = TRACK_WIDTH;

    // Configuration state
    logic [4:0]    r_clb;
    logic [3:0]    r_cb0;
    logic [3:0]    r_cb1;
    logic [2:0]    r_sb_sel [4][NT];
    logic          r_sb_reg [4][NT];

    // Data / pipeline state
    logic [TW-1:0] r_pe_q;
    logic [TW-1:0] r_sb_q   [4][NT];
    logic [31:0]   r_rdata;
    logic          r_rvalid;

    logic [15:0]   w_mod;
    logic          w_tile_hit;
    logic          w_wr;
    logic          w_rd;
    logic [31:0]   w_rd_val;
    logic [TW-1:0] w_op0;
    logic [TW-1:0] w_op1;
    logic [3:0]    w_tt;
    logic [TW-1:0] w_lut;
    logic [TW-1:0] w_pe;
    logic [TW-1:0] w_sb_mux [4][NT];
    logic          w_unused_data;

    assign w_mod      = i_config_addr[31:16];
    assign w_tile_hit = (i_config_addr[15:0] == i_tile_id);
    assign w_wr       = i_config_en && w_tile_hit;
    assign w_rd       = i_config_rd && w_tile_hit;

    // Only the low five data bits ever land in a register.
    assign w_unused_data = ^i_config_data[31:5];

    // Connect boxes: codes 0..NT-1 pick side 0, NT..2NT-1 pick side 1,
    // anything larger leaves the operand at 0.
    always_comb begin
        w_op0 = '0;
        w_op1 = '0;
        for (int t = 0; t < NT; t++) begin
            if (r_cb0 == 4'(t))      w_op0 = i_in_wire[t*TW +: TW];
            if (r_cb0 == 4'(NT + t)) w_op0 = i_in_wire[(NT + t)*TW +: TW];
            if (r_cb1 == 4'(t))      w_op1 = i_in_wire[t*TW +: TW];
            if (r_cb1 == 4'(NT + t)) w_op1 = i_in_wire[(NT + t)*TW +: TW];
        end
    end

    // Bitwise 2-input LUT: each bit lane indexes the truth table independently.
    assign w_tt = r_clb[3:0];

    always_comb begin
        w_lut = '0;
        for (int i = 0; i < TW; i++) begin
            w_lut[i] = w_tt[{w_op1[i], w_op0[i]}];
        end
    end

    assign w_pe     = r_clb[4] ? r_pe_q : w_lut;
    assign o_pe_out = w_pe;

    // Switch box muxes. Sources are in_wire tracks and pe_out only, and the
    // LUT sees in_wire only, so no loop can close inside the tile.
    always_comb begin
        for (int s = 0; s < 4; s++) begin
            for (int t = 0; t < NT; t++) begin
                case (r_sb_sel[s][t])
                    3'd0:    w_sb_mux[s][t] = i_in_wire[(0*NT + t)*TW +: TW];
                    3'd1:    w_sb_mux[s][t] = i_in_wire[(1*NT + t)*TW +: TW];
                    3'd2:    w_sb_mux[s][t] = i_in_wire[(2*NT + t)*TW +: TW];
                    3'd3:    w_sb_mux[s][t] = i_in_wire[(3*NT + t)*TW +: TW];
                    3'd4:    w_sb_mux[s][t] = w_pe;
                    default: w_sb_mux[s][t] = '0;
                endcase
            end
        end
    end

    // Masked sides are tied off; their config registers remain live.
    always_comb begin
        o_out_wire = '0;
        for (int s = 0; s < 4; s++) begin
            for (int t = 0; t < NT; t++) begin
                if (SIDE_MASK[s]) begin
                    o_out_wire[(s*NT + t)*TW +: TW] =
                        r_sb_reg[s][t] ? r_sb_q[s][t] : w_sb_mux[s][t];
                end
            end
        end
    end

    // Readback source, taken from the pre-edge register contents.
    always_comb begin
        w_rd_val = '0;
        if (w_mod == 16'h0000) w_rd_val = {27'd0, r_clb};
        if (w_mod == 16'h0001) w_rd_val = {28'd0, r_cb0};
        if (w_mod == 16'h0002) w_rd_val = {28'd0, r_cb1};
        for (int s = 0; s < 4; s++) begin
            for (int t = 0; t < NT; t++) begin
                if (w_mod == 16'(256 + 16*s + t)) begin
                    w_rd_val = {28'd0, r_sb_reg[s][t], r_sb_sel[s][t]};
                end
            end
        end
    end

    // Configuration registers
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_clb <= '0;
            r_cb0 <= '0;
            r_cb1 <= '0;
            for (int s = 0; s < 4; s++) begin
                for (int t = 0; t < NT; t++) begin
                    r_sb_sel[s][t] <= 3'b111;
                    r_sb_reg[s][t] <= 1'b0;
                end
            end
        end else if (w_wr) begin
            if (w_mod == 16'h0000) r_clb <= i_config_data[4:0];
            if (w_mod == 16'h0001) r_cb0 <= i_config_data[3:0];
            if (w_mod == 16'h0002) r_cb1 <= i_config_data[3:0];
            for (int s = 0; s < 4; s++) begin
                for (int t = 0; t < NT; t++) begin
                    if (w_mod == 16'(256 + 16*s + t)) begin
                        r_sb_sel[s][t] <= i_config_data[2:0];
                        r_sb_reg[s][t] <= i_config_data[3];
                    end
                end
            end
        end
    end

    // Pipeline flops run every cycle, independent of config traffic.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_pe_q <= '0;
            for (int s = 0; s < 4; s++) begin
                for (int t = 0; t < NT; t++) begin
                    r_sb_q[s][t] <= '0;
                end
            end
        end else begin
            r_pe_q <= w_lut;
            for (int s = 0; s < 4; s++) begin
                for (int t = 0; t < NT; t++) begin
                    r_sb_q[s][t] <= w_sb_mux[s][t];
                end
            end
        end
    end

    // Readback port: rdata holds between accepted reads.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_rdata  <= '0;
            r_rvalid <= 1'b0;
        end else begin
            r_rvalid <= w_rd;
            if (w_rd) r_rdata <= w_rd_val;
        end
    end

    assign o_config_rdata  = r_rdata;
    assign o_config_rvalid = r_rvalid;

endmodule
